// File: rtl/fc_acc_argmax.sv
// fc_acc_argmax: accumulates per-chunk partial-sum pairs from the FC GEMM
// stage into saturating signed accumulators, one per output channel, then
// scans them and reports the index and value of the largest one.
module fc_acc_argmax #(
    parameter int DATA_WIDTH     = 8,
    parameter int ACC_WIDTH      = 16,
    parameter int OUTPUT_CHANNEL = 10,
    parameter int CHUNKS         = 16,
    parameter int IDX_WIDTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic signed [DATA_WIDTH-1:0] psum1,
    input  logic signed [DATA_WIDTH-1:0] psum2,
    output logic                         busy,
    output logic                         done,
    output logic        [IDX_WIDTH-1:0]  number,
    output logic signed [ACC_WIDTH-1:0]  max_value
);

    localparam int NUM_PAIRS = OUTPUT_CHANNEL / 2;
    localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int CHUNK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SCAN_W    = $clog2(OUTPUT_CHANNEL + 1);

    localparam logic [PAIR_W-1:0]  LAST_PAIR  = PAIR_W'(NUM_PAIRS - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_END   = SCAN_W'(OUTPUT_CHANNEL);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [ACC_WIDTH-1:0] r_acc [OUTPUT_CHANNEL];
    logic        [PAIR_W-1:0]    r_pair;
    logic        [CHUNK_W-1:0]   r_chunk;
    logic        [SCAN_W-1:0]    r_scan;
    logic signed [ACC_WIDTH-1:0] r_best_val;
    logic        [IDX_WIDTH-1:0] r_best_idx;

    logic                        w_hs;
    logic                        w_last_hs;
    logic signed [ACC_WIDTH-1:0] w_scan_val;

    // Add a sign-extended partial sum to an accumulator, clamping at the
    // signed ACC_WIDTH limits instead of wrapping.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0]  a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    // A start pulse always wins, so the pair offered alongside it is refused.
    assign psum_ready = (r_state == S_ACCUM) && !start;
    assign busy       = (r_state == S_ACCUM) || (r_state == S_SCAN);
    assign done       = (r_state == S_DONE);
    assign w_hs       = psum_valid && psum_ready;
    assign w_last_hs  = w_hs && (r_pair == LAST_PAIR) && (r_chunk == LAST_CHUNK);

    // Select the accumulator addressed by the scan counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_scan_val = '0;
        for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
            if (SCAN_W'(i) == r_scan) begin
                w_scan_val = r_acc[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start restarts from any state.
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_ACCUM;
        end else begin
            unique case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_ACCUM: if (w_last_hs) w_next_state = S_SCAN;
                S_SCAN:  if (r_scan == SCAN_END) w_next_state = S_DONE;
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Datapath: accumulate pairs, run the argmax scan, publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator array is reset explicitly so a mid-run reset discards partial sums.
            for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                r_acc[i] <= '0;
            end
            r_pair     <= '0;
            r_chunk    <= '0;
            r_scan     <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            number     <= '0;
            max_value  <= '0;
        end else if (start) begin
            for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                r_acc[i] <= '0;
            end
            r_pair     <= '0;
            r_chunk    <= '0;
            r_scan     <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_hs) begin
                        for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                            if (i == 2 * int'(r_pair)) begin
                                r_acc[i] <= sat_add(r_acc[i], psum1);
                            end else if (i == 2 * int'(r_pair) + 1) begin
                                r_acc[i] <= sat_add(r_acc[i], psum2);
                            end
                        end
                        if (r_chunk == LAST_CHUNK) begin
                            r_chunk <= '0;
                            r_pair  <= (r_pair == LAST_PAIR) ? '0 : r_pair + 1'b1;
                        end else begin
                            r_chunk <= r_chunk + 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_scan == SCAN_END) begin
                        number    <= r_best_idx;
                        max_value <= r_best_val;
                        r_scan    <= '0;
                    end else begin
                        // Strict greater-than keeps the lowest index on ties.
                        if ((r_scan == '0) || (w_scan_val > r_best_val)) begin
                            r_best_val <= w_scan_val;
                            r_best_idx <= IDX_WIDTH'(r_scan);
                        end
                        r_scan <= r_scan + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
